uart_rx_fifo: RTL and testbench

Receive half of the board's UART link. It takes the asynchronous serial input from the UART RX pin and samples it at mid-bit, 8N1 framing. It places each good byte into a small show-ahead FIFO and presents it to the consumer with the same ready/ack handshake the SPI slave uses. In the top level it feeds UART bytes toward the SPI side, as the return path of the existing SPI→UART echo.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver state encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit (integer division). The transmitter uses the same value.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Cycles from the start-bit falling edge to mid start bit.
    function automatic int calc_half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock show-ahead FIFO: pop_data always shows the entry at the read pointer.
// Latency: a push is visible on pop_data/count the cycle after the write edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
//
// Ports: clk, reset (sync, active high), push/push_data, pop/pop_data,
//        full, empty, count (0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage carries no reset; the consumer only looks at it while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling feeding a show-ahead byte FIFO.
// Latency: start-bit falling edge to rx_data_ready = 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT cycles.
// Backpressure: none on the line; a good byte arriving while the FIFO is full (and not popped that cycle) is dropped with an overrun pulse.
//
// Ports: clk, reset (sync, active high), uart_rx_pin (async, idle high),
//        rx_data/rx_data_ready/rx_read_ack (consumer handshake, ack pops head),
//        fifo_count, frame_error and overrun (single-cycle pulses).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_data_ready,
    input  logic                          rx_read_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    // Two-flop synchronizer; both stages reset to the idle (high) level.
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_pin;
            rxs     <= rx_meta;
        end
    end

    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic             stop_sample;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;
    logic [7:0]       fifo_head;

    // The push is combinational so the byte lands on the stop-sample edge itself.
    assign stop_sample = (state == ST_STOP) && (baud_cnt == BIT_END);
    assign fifo_push   = stop_sample && rxs;
    // A full FIFO being popped on the same edge still takes the byte.
    assign drop        = fifo_push && fifo_full && !rx_read_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!rxs) state <= ST_START;
                end
                ST_START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        // Line back high at mid start bit: a glitch, silently ignored.
                        if (!rxs) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        shreg    <= {rxs, shreg[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        if (rxs) begin
                            overrun <= drop;
                            state   <= ST_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // Holding here until the line recovers gives one error per break.
                    baud_cnt <= '0;
                    if (rxs) state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (shreg),
        .pop       (rx_read_ack),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Uninitialised storage is hidden while empty so reset reads back as zero.
    assign rx_data_ready = !fifo_empty;
    assign rx_data       = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (234 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB = 234;   // 27000000 / 115200, truncated

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx_pin = 1'b1;
    logic       rx_read_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic [4:0] fifo_count;
    logic       frame_error;
    logic       overrun;

    uart_rx_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx_pin   (uart_rx_pin),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_read_ack   (rx_read_ack),
        .fifo_count    (fifo_count),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters: counting high cycles also catches pulses wider than one cycle.
    int fe_cnt = 0;
    int ov_cnt = 0;
    always @(negedge clk) begin
        if (frame_error) fe_cnt++;
        if (overrun)     ov_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, optional low stop period, then one high stop bit.
    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        uart_rx_pin = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            hold(CPB);
        end
        if (stop_low_bits > 0) begin
            uart_rx_pin = 1'b0;
            hold(CPB * stop_low_bits);
        end
        uart_rx_pin = 1'b1;
        hold(CPB);
    endtask

    task automatic pop_one();
        rx_read_ack = 1'b1;
        hold(1);
        rx_read_ack = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c0;
    int t_rdy;
    int fe0;
    int ov0;

    initial begin
        // Reset state.
        hold(3);
        @(negedge clk);
        check("rst_data",  rx_data, 8'h00);
        check("rst_rdy",   rx_data_ready, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_fe",    frame_error, 1'b0);
        check("rst_ov",    overrun, 1'b0);
        check("rst_state", dut.state, ST_IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
        hold(5);

        // 0x55 with latency measurement: 2 + 1 + 117 + 9*234 = 2226 cycles.
        c0 = cyc;
        t_rdy = 0;
        fork
            send_frame(8'h55, 0);
            begin
                for (int k = 0; k < 3000; k++) begin
                    @(negedge clk);
                    if (rx_data_ready) break;
                end
                t_rdy = cyc;
            end
        join
        check("lat_55", t_rdy - c0, 2226);
        @(negedge clk);
        check("data_55",  rx_data, 8'h55);
        check("rdy_55",   rx_data_ready, 1'b1);
        check("count_55", fifo_count, 5'd1);
        pop_one();
        @(negedge clk);
        check("pop_rdy",   rx_data_ready, 1'b0);
        check("pop_count", fifo_count, 5'd0);
        // Ack while empty is ignored.
        pop_one();
        @(negedge clk);
        check("uf_count", fifo_count, 5'd0);
        check("uf_rdy",   rx_data_ready, 1'b0);

        // Start-bit glitch: 50 low cycles.
        fe0 = fe_cnt;
        uart_rx_pin = 1'b0;
        hold(50);
        uart_rx_pin = 1'b1;
        hold(300);
        @(negedge clk);
        check("gl_fe",    fe_cnt - fe0, 0);
        check("gl_count", fifo_count, 5'd0);
        check("gl_state", dut.state, ST_IDLE);

        // 0xA3 with stop held low for two bit times, then a good 0x3C.
        fe0 = fe_cnt;
        send_frame(8'hA3, 2);
        hold(10);
        @(negedge clk);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_count", fifo_count, 5'd0);
        send_frame(8'h3C, 0);
        @(negedge clk);
        check("data_3c",  rx_data, 8'h3C);
        check("count_3c", fifo_count, 5'd1);
        check("fe_once",  fe_cnt - fe0, 1);

        // Push and pop together at count 1: 0x5A replaces 0x3C as head.
        hold(1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h5A, 0);
            begin
                hold(2225);
                rx_read_ack = 1'b1;
                @(posedge clk); #1;
                rx_read_ack = 1'b0;
                @(negedge clk);
                check("c1_rdy",   rx_data_ready, 1'b1);
                check("c1_data",  rx_data, 8'h5A);
                check("c1_count", fifo_count, 5'd1);
            end
        join
        check("c1_ov", ov_cnt - ov0, 0);
        pop_one();
        @(negedge clk);
        check("c1_empty", fifo_count, 5'd0);

        // Fill with 0x00..0x0F, then 0x10 overruns.
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 0);
        @(negedge clk);
        check("full_count", fifo_count, 5'd16);
        check("full_ov",    ov_cnt - ov0, 0);
        send_frame(8'h10, 0);
        @(negedge clk);
        check("ov_pulse", ov_cnt - ov0, 1);
        check("ov_count", fifo_count, 5'd16);
        check("ov_head",  rx_data, 8'h00);

        // Full FIFO, ack on the stop-sample edge of 0x77: pops 0x00, accepts 0x77.
        hold(1);
        fork
            send_frame(8'h77, 0);
            begin
                hold(2225);
                rx_read_ack = 1'b1;
                @(posedge clk); #1;
                rx_read_ack = 1'b0;
            end
        join
        @(negedge clk);
        check("fp_ov",    ov_cnt - ov0, 1);
        check("fp_count", fifo_count, 5'd16);
        @(posedge clk); #1;

        // Back-to-back acks drain 0x01..0x0F; 0x77 stays as the head.
        rx_read_ack = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("drain_%0d", i), rx_data, 8'(i));
        end
        @(posedge clk); #1;
        rx_read_ack = 1'b0;
        @(negedge clk);
        check("last_77",    rx_data, 8'h77);
        check("last_count", fifo_count, 5'd1);

        // One-cycle reset in the middle of 0xFF's data bits, then 0x12.
        hold(1);
        fork
            send_frame(8'hFF, 0);
            begin
                hold(1000);
                reset = 1'b1;
                hold(1);
                @(negedge clk);
                check("mr_data",  rx_data, 8'h00);
                check("mr_rdy",   rx_data_ready, 1'b0);
                check("mr_count", fifo_count, 5'd0);
                check("mr_fe",    frame_error, 1'b0);
                check("mr_ov",    overrun, 1'b0);
                check("mr_state", dut.state, ST_IDLE);
                reset = 1'b0;
            end
        join
        hold(5);
        @(negedge clk);
        check("post_rst_count", fifo_count, 5'd0);
        send_frame(8'h12, 0);
        @(negedge clk);
        check("data_12",  rx_data, 8'h12);
        check("count_12", fifo_count, 5'd1);
        pop_one();
        @(negedge clk);
        check("end_count", fifo_count, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
